// File: rtl/slice_tx_gate.sv
// TDMA slice consumer: admits frames from four TX queues only inside their own open slice
// when airtime plus guard fits the time left. Optional counters under SLICE_TX_GATE_STATS_EN.

module slice_tx_gate_lane #(
  parameter int DUR_WIDTH    = 16,
  parameter int SLICE_WIDTH  = 25,
  parameter int GUARD_CYCLES = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [SLICE_WIDTH-1:0] len,
  input  logic [DUR_WIDTH-1:0]   dur,
  output logic                   en_d,
  output logic                   open,
  output logic                   fits
);
  logic [SLICE_WIDTH-1:0] rem;
  logic [SLICE_WIDTH:0]   need;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_d <= 1'b0;
      rem  <= '0;
    end else begin
      en_d <= en;
      if (!en)            rem <= '0;
      else if (!en_d)     rem <= len;
      else if (rem != '0) rem <= rem - 1'b1;
    end
  end

  // One extra bit so a long frame plus guard cannot wrap past a short remainder
  assign need = (SLICE_WIDTH+1)'(dur) + (SLICE_WIDTH+1)'(GUARD_CYCLES);
  assign fits = (need <= {1'b0, rem});
  assign open = en & en_d;
endmodule

module slice_tx_gate #(
  parameter int NUM_Q        = 4,
  parameter int DUR_WIDTH    = 16,
  parameter int SLICE_WIDTH  = 25,
  parameter int GUARD_CYCLES = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_Q-1:0]             slice_en,
  input  logic [NUM_Q*SLICE_WIDTH-1:0] slice_len,
  input  logic [NUM_Q-1:0]             pkt_rdy,
  input  logic [NUM_Q*DUR_WIDTH-1:0]   pkt_dur,
  input  logic                         tx_done,
  input  logic                         ovr_clr,
`ifdef SLICE_TX_GATE_STATS_EN
  input  logic [1:0]                   stat_sel,
  output logic [15:0]                  stat_grant,
  output logic [15:0]                  stat_defer,
`endif
  output logic                         tx_start,
  output logic [1:0]                   tx_qidx,
  output logic                         tx_busy,
  output logic [NUM_Q-1:0]             slice_ovr
);
  localparam int GW = $clog2(GUARD_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, GRANT, TX, GUARD} state_t;

  state_t           state, state_nx;
  logic [NUM_Q-1:0] en_d, open, fits, elig;
  logic [1:0]       rr, win, idx;
  logic             any;
  logic [GW-1:0]    gcnt;
  logic             ovr_set;

  for (genvar i = 0; i < NUM_Q; i++) begin : g_lane
    slice_tx_gate_lane #(
      .DUR_WIDTH(DUR_WIDTH), .SLICE_WIDTH(SLICE_WIDTH), .GUARD_CYCLES(GUARD_CYCLES)
    ) u_lane (
      .clk (clk),
      .rst (rst),
      .en  (slice_en[i]),
      .len (slice_len[i*SLICE_WIDTH +: SLICE_WIDTH]),
      .dur (pkt_dur[i*DUR_WIDTH +: DUR_WIDTH]),
      .en_d(en_d[i]),
      .open(open[i]),
      .fits(fits[i])
    );
  end

  assign elig = pkt_rdy & open & fits;

  // Round-robin: scan from rr+1, wrapping back to rr last
  always_comb begin
    win = rr;
    any = 1'b0;
    idx = '0;
    for (int k = 1; k <= NUM_Q; k++) begin
      idx = rr + k[1:0];
      if (elig[idx] && !any) begin
        win = idx;
        any = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    tx_start = 1'b0;
    tx_busy  = 1'b1;
    unique case (state)
      IDLE: begin
        tx_busy = 1'b0;
        if (any) state_nx = GRANT;
      end
      GRANT: begin
        tx_start = 1'b1;
        state_nx = TX;
      end
      TX:      if (tx_done) state_nx = GUARD;
      GUARD:   if (gcnt == '0) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_qidx <= '0;
      rr      <= '0;
      gcnt    <= '0;
    end else begin
      if (state == IDLE && any) begin
        tx_qidx <= win;
        rr      <= win;
      end
      if (state == TX && tx_done)          gcnt <= GW'(GUARD_CYCLES - 1);
      else if (state == GUARD && gcnt != '0) gcnt <= gcnt - 1'b1;
    end
  end

  // Slice closed under an in-flight frame; the frame still runs to tx_done
  assign ovr_set = (state == GRANT || state == TX) && en_d[tx_qidx] && !slice_en[tx_qidx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) slice_ovr <= '0;
    else begin
      if (ovr_clr) slice_ovr <= '0;
      if (ovr_set) slice_ovr[tx_qidx] <= 1'b1;
    end
  end

`ifdef SLICE_TX_GATE_STATS_EN
  logic [NUM_Q-1:0][15:0] grant_cnt, defer_cnt;
  logic [NUM_Q-1:0]       defer_seen;

  // A slice counts as deferred once, on the first cycle the head frame failed to fit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_cnt  <= '0;
      defer_cnt  <= '0;
      defer_seen <= '0;
      stat_grant <= '0;
      stat_defer <= '0;
    end else begin
      for (int i = 0; i < NUM_Q; i++) begin
        if (!open[i]) defer_seen[i] <= 1'b0;
        else if (pkt_rdy[i] && !fits[i]) defer_seen[i] <= 1'b1;
        if (ovr_clr) begin
          grant_cnt[i] <= '0;
          defer_cnt[i] <= '0;
        end else begin
          if (tx_start && tx_qidx == i[1:0] && grant_cnt[i] != 16'hFFFF)
            grant_cnt[i] <= grant_cnt[i] + 1'b1;
          if (open[i] && pkt_rdy[i] && !fits[i] && !defer_seen[i] && defer_cnt[i] != 16'hFFFF)
            defer_cnt[i] <= defer_cnt[i] + 1'b1;
        end
      end
      stat_grant <= grant_cnt[stat_sel];
      stat_defer <= defer_cnt[stat_sel];
    end
  end
`endif
endmodule

// File: tb/tb_slice_tx_gate.sv
// Directed bench for slice_tx_gate: grant timing, fit check, round-robin, overrun, async reset,
// and the SLICE_TX_GATE_STATS_EN counters when that macro is defined.

module tb_slice_tx_gate;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  slice_en, pkt_rdy;
  logic [99:0] slice_len;
  logic [63:0] pkt_dur;
  logic        tx_done, ovr_clr;
  logic        tx_start, tx_busy;
  logic [1:0]  tx_qidx;
  logic [3:0]  slice_ovr;
`ifdef SLICE_TX_GATE_STATS_EN
  logic [1:0]  stat_sel;
  logic [15:0] stat_grant, stat_defer;
`endif

  int vectors = 0;
  int miscompares = 0;
  bit ok, seen;
  int order [5] = '{1, 2, 3, 0, 1};

  slice_tx_gate dut (
    .clk(clk), .rst(rst), .slice_en(slice_en), .slice_len(slice_len),
    .pkt_rdy(pkt_rdy), .pkt_dur(pkt_dur), .tx_done(tx_done), .ovr_clr(ovr_clr),
`ifdef SLICE_TX_GATE_STATS_EN
    .stat_sel(stat_sel), .stat_grant(stat_grant), .stat_defer(stat_defer),
`endif
    .tx_start(tx_start), .tx_qidx(tx_qidx), .tx_busy(tx_busy), .slice_ovr(slice_ovr)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_start(output bit found);
    found = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (tx_start) begin
        found = 1'b1;
        break;
      end
      step(1);
    end
  endtask

  // tx_done pulse, then the full guard interval so the FSM is back in IDLE
  task automatic finish_frame();
    tx_done = 1'b1;
    step(1);
    tx_done = 1'b0;
    step(33);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; slice_en = '0; pkt_rdy = '0; slice_len = '0; pkt_dur = '0;
    tx_done = 1'b0; ovr_clr = 1'b0;
`ifdef SLICE_TX_GATE_STATS_EN
    stat_sel = '0;
`endif
    step(2);
    check("rst_start", tx_start, 0);
    check("rst_busy", tx_busy, 0);
    check("rst_qidx", tx_qidx, 0);
    check("rst_ovr", slice_ovr, 0);
    rst = 1'b0;
    step(1);

    // Single grant on queue 0
    slice_len[0 +: 25] = 25'd1000; pkt_dur[0 +: 16] = 16'd100;
    pkt_rdy[0] = 1'b1; slice_en[0] = 1'b1;
    step(1);
    check("sg_not_in_open_cycle", tx_start, 0);
    step(1);
    check("sg_start", tx_start, 1);
    check("sg_qidx", tx_qidx, 0);
    check("sg_busy", tx_busy, 1);
    step(1);
    check("sg_start_one_cycle", tx_start, 0);
    step(100);
    tx_done = 1'b1; step(1); tx_done = 1'b0;
    step(31);
    check("guard_busy_last", tx_busy, 1);
    step(1);
    check("guard_end", tx_busy, 0);
    step(1);
    check("regrant_min_gap", tx_start, 1);
    pkt_rdy[0] = 1'b0;
    step(1);
    finish_frame();
    slice_en[0] = 1'b0;
    step(2);
    check("sg_idle", tx_busy, 0);

    // Round-robin with all four slices open
    for (int i = 0; i < 4; i++) begin
      slice_len[i*25 +: 25] = 25'd1000;
      pkt_dur[i*16 +: 16] = 16'd10;
    end
    pkt_rdy = 4'hF; slice_en = 4'hF;
    for (int n = 0; n < 5; n++) begin
      wait_start(ok);
      check("rr_start", ok, 1);
      check("rr_qidx", tx_qidx, order[n]);
      step(5);
      tx_done = 1'b1; step(1); tx_done = 1'b0;
    end
    slice_en = '0; pkt_rdy = '0;
    step(35);
    check("rr_no_ovr", slice_ovr, 0);

    // Fit check on queue 1: 170+32 > 200 never fits, 168+32 = 200 fits on the first open cycle
    slice_len[25 +: 25] = 25'd200; pkt_dur[16 +: 16] = 16'd170;
    pkt_rdy[1] = 1'b1; slice_en[1] = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step(1);
      if (tx_start) seen = 1'b1;
    end
    check("fit_reject", seen, 0);
    slice_en[1] = 1'b0;
    step(2);
    pkt_dur[16 +: 16] = 16'd168; slice_en[1] = 1'b1;
    step(2);
    check("fit_exact", tx_start, 1);
    check("fit_qidx", tx_qidx, 1);
    tx_done = 1'b1; step(1); tx_done = 1'b0;
    step(40);
    check("done_in_grant_ignored", tx_busy, 1);
    pkt_rdy[1] = 1'b0;
    tx_done = 1'b1; step(1); tx_done = 1'b0;
    slice_en[1] = 1'b0;
    step(34);
    check("fit_idle", tx_busy, 0);

    // Overrun on queue 2
    slice_len[50 +: 25] = 25'd1000; pkt_dur[32 +: 16] = 16'd10;
    pkt_rdy[2] = 1'b1; slice_en[2] = 1'b1;
    wait_start(ok);
    check("ovr_start", ok, 1);
    check("ovr_qidx", tx_qidx, 2);
    step(1);
    pkt_rdy[2] = 1'b0; slice_en[2] = 1'b0;
    step(1);
    check("ovr_set", slice_ovr, 4'b0100);
    step(3);
    check("ovr_hold", slice_ovr, 4'b0100);
    check("ovr_no_abort", tx_busy, 1);
    finish_frame();
    check("ovr_sticky", slice_ovr, 4'b0100);
    ovr_clr = 1'b1; step(1); ovr_clr = 1'b0;
    check("ovr_clr", slice_ovr, 0);
    pkt_rdy[2] = 1'b1; slice_en[2] = 1'b1;
    wait_start(ok);
    check("ovr2_start", ok, 1);
    step(1);
    pkt_rdy[2] = 1'b0; slice_en[2] = 1'b0; ovr_clr = 1'b1;
    step(1);
    ovr_clr = 1'b0;
    check("ovr_set_beats_clr", slice_ovr, 4'b0100);
    finish_frame();
    ovr_clr = 1'b1; step(1); ovr_clr = 1'b0;

    // Async reset mid-frame on queue 3
    slice_len[75 +: 25] = 25'd1000; pkt_dur[48 +: 16] = 16'd10;
    pkt_rdy[3] = 1'b1; slice_en[3] = 1'b1;
    wait_start(ok);
    check("ar_start", ok, 1);
    step(1);
    check("ar_busy_before", tx_busy, 1);
    #2;
    rst = 1'b1; slice_en[3] = 1'b0;
    #1;
    check("ar_busy_async", tx_busy, 0);
    check("ar_start_async", tx_start, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (tx_start) seen = 1'b1;
    end
    check("ar_no_grant_without_edge", seen, 0);
    check("ar_qidx_cleared", tx_qidx, 0);
    slice_en[3] = 1'b1;
    step(2);
    check("ar_fresh_edge_grant", tx_start, 1);
    check("ar_fresh_qidx", tx_qidx, 3);
    pkt_rdy[3] = 1'b0;
    step(1);
    finish_frame();
    slice_en[3] = 1'b0;
    step(2);

`ifdef SLICE_TX_GATE_STATS_EN
    // One deferred slice then three grants on queue 0
    ovr_clr = 1'b1; step(1); ovr_clr = 1'b0;
    slice_len[0 +: 25] = 25'd200; pkt_dur[0 +: 16] = 16'd170;
    pkt_rdy[0] = 1'b1; slice_en[0] = 1'b1;
    step(6);
    slice_en[0] = 1'b0;
    step(2);
    slice_len[0 +: 25] = 25'd1000; pkt_dur[0 +: 16] = 16'd10; slice_en[0] = 1'b1;
    for (int n = 0; n < 3; n++) begin
      wait_start(ok);
      check("st_start", ok, 1);
      step(1);
      if (n == 2) pkt_rdy[0] = 1'b0;
      finish_frame();
    end
    slice_en[0] = 1'b0; stat_sel = 2'd0;
    step(2);
    check("st_grant", stat_grant, 3);
    check("st_defer", stat_defer, 1);
    ovr_clr = 1'b1; step(1); ovr_clr = 1'b0;
    step(1);
    check("st_grant_clr", stat_grant, 0);
    check("st_defer_clr", stat_defer, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
